// File: rtl/rf_scan_controller_pkg.sv
// Shared CNN scan definitions: state encoding, default image/kernel geometry
// and the output-row / output-buffer address width derivation.
package rf_scan_controller_pkg;

    localparam int unsigned H_DEFAULT = 32;
    localparam int unsigned W_DEFAULT = 32;
    localparam int unsigned F_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } scan_state_t;

    function automatic int unsigned out_rows(input int unsigned h, input int unsigned f);
        return h - f + 1;
    endfunction

    // Two half-row slots per output row.
    function automatic int unsigned addr_width(input int unsigned h, input int unsigned f);
        return $clog2(2 * (h - f + 1));
    endfunction

endpackage

// File: rtl/rf_scan_controller_if.sv
// Scan controller bus: layer-control start/busy/done, selector row/half select,
// convolution-bank handshake and output-buffer write port.
interface rf_scan_controller_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic [5:0]        row_number;
    logic [5:0]        column;
    logic              rf_valid;
    logic              rf_ready;
    logic              conv_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        input  start, rf_ready, conv_valid,
        output busy, done, row_number, column, rf_valid, wr_en, wr_addr
    );

    modport slave (
        output start, rf_ready, conv_valid,
        input  busy, done, row_number, column, rf_valid, wr_en, wr_addr
    );

endinterface

// File: rtl/rf_scan_counter.sv
// Row / half-row step counter for the receptive-field scan.
module rf_scan_counter #(
    parameter int unsigned OUT_H = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    output logic [5:0] row,
    output logic       col,
    output logic       last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= 1'b0;
        end else if (clear) begin
            row <= '0;
            col <= 1'b0;
        end else if (advance) begin
            col <= ~col;
            if (col) begin
                row <= row + 6'd1;
            end
        end
    end

    assign last = (row == 6'(OUT_H - 1)) && col;

endmodule

// File: rtl/rf_scan_controller.sv
// Sequencer walking every output row in two half-row passes: select, hand the
// field to the convolution bank, wait for its result, write the output buffer.
module rf_scan_controller
    import rf_scan_controller_pkg::*;
#(
    parameter int unsigned H = H_DEFAULT,
    parameter int unsigned W = W_DEFAULT,
    parameter int unsigned F = F_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rf_scan_controller_if.master   bus
);

    localparam int unsigned OUT_H  = out_rows(H, F);
    localparam int unsigned ADDR_W = addr_width(H, F);

    if ((F > H) || (F > W) || (OUT_H > 64) || (((W - F + 1) % 2) != 0)) begin : g_bad_cfg
        $error("rf_scan_controller: illegal H/W/F configuration");
    end

    scan_state_t state;
    logic [5:0]  row;
    logic        col;
    logic        last;
    logic        clear;
    logic        advance;

    assign clear   = (state == ST_IDLE) && bus.start;
    assign advance = (state == ST_WRITE) && !last;

    rf_scan_counter #(
        .OUT_H (OUT_H)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (advance),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    // Selector inputs come straight from the counter registers so the field
    // cannot move between the handshake and the convolution result.
    assign bus.row_number = row;
    assign bus.column     = {5'd0, col};
    assign bus.wr_addr    = ADDR_W'({row, col});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rf_valid <= 1'b0;
            bus.wr_en    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state        <= ST_ISSUE;
                        bus.busy     <= 1'b1;
                        bus.rf_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.rf_ready) begin
                        state        <= ST_WAIT;
                        bus.rf_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.conv_valid) begin
                        state     <= ST_WRITE;
                        bus.wr_en <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    bus.wr_en <= 1'b0;
                    if (last) begin
                        state    <= ST_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state        <= ST_ISSUE;
                        bus.rf_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b0;
                    bus.rf_valid <= 1'b0;
                    bus.wr_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_scan_controller.sv
// Directed bench for rf_scan_controller: default 32x32/F5 instance and a small
// 8x8/F3 instance, each scan driven by a cycle-accurate bank responder.
module tb_rf_scan_controller;

    logic clk;
    logic rst_n;
    logic start;
    logic rf_ready;
    logic conv_valid;
    logic sel;

    int errors = 0;
    int checks = 0;

    rf_scan_controller_if #(.ADDR_W(6)) bus_a ();
    rf_scan_controller_if #(.ADDR_W(4)) bus_b ();

    rf_scan_controller #(.H(32), .W(32), .F(5)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    rf_scan_controller #(.H(8), .W(8), .F(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    assign bus_a.start      = start & ~sel;
    assign bus_b.start      = start & sel;
    assign bus_a.rf_ready   = rf_ready;
    assign bus_b.rf_ready   = rf_ready;
    assign bus_a.conv_valid = conv_valid;
    assign bus_b.conv_valid = conv_valid;

    logic       o_busy, o_done, o_rfv, o_wr;
    logic [5:0] o_row, o_col;
    logic [6:0] o_addr;

    assign o_busy = sel ? bus_b.busy       : bus_a.busy;
    assign o_done = sel ? bus_b.done       : bus_a.done;
    assign o_rfv  = sel ? bus_b.rf_valid   : bus_a.rf_valid;
    assign o_wr   = sel ? bus_b.wr_en      : bus_a.wr_en;
    assign o_row  = sel ? bus_b.row_number : bus_a.row_number;
    assign o_col  = sel ? bus_b.column     : bus_a.column;
    assign o_addr = sel ? 7'(bus_b.wr_addr) : 7'(bus_a.wr_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the most recent scan.
    int t_done, n_wr, n_hs, n_done, n_stall_iss, max_row, last_addr;
    bit order_ok, aborted;

    // Starts one scan and answers the bank handshake each cycle until done
    // (plus 4 idle cycles) or until the abort row is seen in WAIT.
    task automatic run_scan(input int stall_step, input int stall_n, input bit spur,
                            input int mid_start, input bit done_start, input int abort_row);
        int  step = 0;
        int  stalled = 0;
        int  wait_cnt = 0;
        int  next_addr = 0;
        bit  hs_prev = 0;
        bit  real_cv;
        t_done = -1; n_wr = 0; n_hs = 0; n_done = 0; n_stall_iss = 0;
        max_row = 0; last_addr = -1; order_ok = 1; aborted = 0;
        @(negedge clk);
        start = 1'b1; rf_ready = 1'b1; conv_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (int'(o_row) > max_row) max_row = int'(o_row);
            if (o_wr) begin
                n_wr++;
                if (int'(o_addr) != next_addr) order_ok = 0;
                last_addr = int'(o_addr);
                next_addr++;
                step++;
            end
            if (o_done) begin
                n_done++;
                if (t_done < 0) t_done = cyc;
            end
            if (abort_row >= 0 && o_busy && !o_rfv && !o_wr && !o_done && int'(o_row) == abort_row) begin
                aborted = 1;
                start = 1'b0; rf_ready = 1'b0; conv_valid = 1'b0;
                return;
            end
            start = (cyc == mid_start) || (done_start && o_done);
            if (o_rfv && step == stall_step && int'(o_row) == step / 2 && int'(o_col) == step % 2)
                n_stall_iss++;
            if (o_rfv && step == stall_step && stalled < stall_n) begin
                rf_ready = 1'b0;
                stalled++;
            end else begin
                rf_ready = 1'b1;
            end
            if (hs_prev) wait_cnt = 1;
            else if (wait_cnt > 0) wait_cnt++;
            real_cv = (wait_cnt == (spur ? 2 : 1));
            if (real_cv) wait_cnt = 0;
            conv_valid = real_cv || (spur && (o_rfv || o_wr));
            hs_prev = o_rfv && rf_ready;
            if (hs_prev) n_hs++;
            if (t_done >= 0 && cyc >= t_done + 4) break;
            @(negedge clk);
        end
        start = 1'b0; rf_ready = 1'b0; conv_valid = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; start = 1'b0; rf_ready = 1'b0; conv_valid = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({o_busy, o_done, o_rfv, o_wr} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {o_busy, o_done, o_rfv, o_wr});
        end
        checks++;
        if (o_row !== 6'd0 || o_col !== 6'd0) begin
            errors++; $display("FAIL reset_rowcol: got %0d/%0d expected 0/0", o_row, o_col);
        end
        checks++;
        if (o_addr !== 7'd0) begin
            errors++; $display("FAIL reset_addr: got %0d expected 0", o_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_scan();
        run_scan(-1, 0, 1'b0, -1, 1'b0, -1);
        checks++;
        if (t_done != 169) begin errors++; $display("FAIL full_done_cycle: got %0d expected 169", t_done); end
        checks++;
        if (n_wr != 56) begin errors++; $display("FAIL full_wr_count: got %0d expected 56", n_wr); end
        checks++;
        if (!order_ok || last_addr != 55) begin
            errors++; $display("FAIL full_addr_order: ok=%0d last=%0d expected ok=1 last=55", order_ok, last_addr);
        end
        checks++;
        if (n_hs != 56) begin errors++; $display("FAIL full_handshakes: got %0d expected 56", n_hs); end
        checks++;
        if (o_busy !== 1'b0 || o_row !== 6'd27 || o_col !== 6'd1) begin
            errors++; $display("FAIL full_hold: busy=%0d row=%0d col=%0d expected 0/27/1", o_busy, o_row, o_col);
        end
    endtask

    task automatic test_ready_stall();
        run_scan(7, 4, 1'b0, -1, 1'b0, -1);
        checks++;
        if (n_stall_iss != 5) begin errors++; $display("FAIL stall_issue_cycles: got %0d expected 5", n_stall_iss); end
        checks++;
        if (t_done != 173) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 173", t_done); end
        checks++;
        if (n_wr != 56 || n_hs != 56) begin
            errors++; $display("FAIL stall_counts: wr=%0d hs=%0d expected 56/56", n_wr, n_hs);
        end
    endtask

    task automatic test_spurious_conv();
        run_scan(-1, 0, 1'b1, -1, 1'b0, -1);
        checks++;
        if (t_done != 225) begin errors++; $display("FAIL spur_done_cycle: got %0d expected 225", t_done); end
        checks++;
        if (n_wr != 56 || !order_ok) begin
            errors++; $display("FAIL spur_writes: wr=%0d ok=%0d expected 56/1", n_wr, order_ok);
        end
    endtask

    task automatic test_start_ignored();
        run_scan(-1, 0, 1'b0, 50, 1'b1, -1);
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL start_done_count: got %0d expected 1", n_done); end
        checks++;
        if (t_done != 169 || n_wr != 56) begin
            errors++; $display("FAIL start_no_restart: done_at=%0d wr=%0d expected 169/56", t_done, n_wr);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_rfv !== 1'b0) begin
            errors++; $display("FAIL start_idle_after: busy=%0d rf_valid=%0d expected 0/0", o_busy, o_rfv);
        end
    endtask

    task automatic test_async_reset();
        run_scan(-1, 0, 1'b0, -1, 1'b0, 10);
        checks++;
        if (!aborted || o_busy !== 1'b1) begin
            errors++; $display("FAIL areset_reach_wait: aborted=%0d busy=%0d expected 1/1", aborted, o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_rfv, o_wr} !== 4'b0000 || o_row !== 6'd0 || o_col !== 6'd0 || o_addr !== 7'd0) begin
            errors++;
            $display("FAIL areset_outputs: flags=%b row=%0d col=%0d addr=%0d expected all 0",
                     {o_busy, o_done, o_rfv, o_wr}, o_row, o_col, o_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(-1, 0, 1'b0, -1, 1'b0, -1);
        checks++;
        if (t_done != 169 || n_wr != 56 || !order_ok) begin
            errors++; $display("FAIL areset_rescan: done_at=%0d wr=%0d ok=%0d expected 169/56/1", t_done, n_wr, order_ok);
        end
    endtask

    task automatic test_small_config();
        sel = 1'b1;
        @(negedge clk);
        run_scan(-1, 0, 1'b0, -1, 1'b0, -1);
        checks++;
        if (n_wr != 12) begin errors++; $display("FAIL small_wr_count: got %0d expected 12", n_wr); end
        checks++;
        if (last_addr != 11 || !order_ok) begin
            errors++; $display("FAIL small_last_addr: got %0d ok=%0d expected 11/1", last_addr, order_ok);
        end
        checks++;
        if (max_row != 5) begin errors++; $display("FAIL small_max_row: got %0d expected 5", max_row); end
        checks++;
        if (t_done != 37) begin errors++; $display("FAIL small_done_cycle: got %0d expected 37", t_done); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_ready_stall();
        test_spurious_conv();
        test_start_ignored();
        test_async_reset();
        test_small_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_scan_controller.md
# rf_scan_controller

Sequencer for the receptive-field selector feeding the convolution bank. On `start` it walks every output row of one F×F convolution over an H×W×D image, two half-row passes per row (column select 0 = left half, 1 = right half). For each step it drives `row_number`/`column` to the selector, handshakes the selected field into the convolution bank, waits for that bank's result, and issues one write to the output feature buffer. It sits between the layer-level control FSM and the selector/convolution/output-buffer datapath.

## Interface
- `H`, 32, image height in pixels
- `W`, 32, image width in pixels
- `F`, 5, kernel size
- Local `OUT_H = H-F+1` (28): output rows per image
- Local `ADDR_W = $clog2(2*OUT_H)` (6): width of the output-buffer address
- Legal configuration: `OUT_H <= 64`, `W-F+1` even, `F <= H`, `F <= W`
- `clk` input 1: single clock; all state updates on the rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: one-cycle request to begin one image scan; sampled only in IDLE
- `busy` output 1: high from the cycle after an accepted `start` through the DONE cycle
- `done` output 1: one-cycle pulse when the final write has been issued
- `row_number` output 6: row select to the selector (0..OUT_H-1)
- `column` output 6: half select to the selector; value is only ever 0 or 1
- `rf_valid` output 1: the field selected by `row_number`/`column` is stable and offered to the convolution bank
- `rf_ready` input 1: the convolution bank accepts the field when `rf_valid && rf_ready`
- `conv_valid` input 1: the convolution bank has produced the result for the accepted field
- `wr_en` output 1: one-cycle write strobe to the output buffer
- `wr_addr` output ADDR_W: output-buffer half-row slot, `row*2 + column`

## Operation
- FSM states:
  - IDLE: `start` → ISSUE, clearing row = 0 and col = 0.
  - ISSUE: `rf_valid` = 1. `rf_ready` → WAIT.
  - WAIT: `conv_valid` → WRITE.
  - WRITE: `wr_en` = 1. If this is the last step (row = OUT_H-1, col = 1) → DONE; otherwise advance the counters → ISSUE.
  - DONE: `done` = 1 → IDLE.
- Counter advance: `col` toggles 0→1. On 1→0 wrap, `row` increments.
- `row_number` and `column` are driven straight from registered counters.
  - They are stable throughout ISSUE, WAIT and WRITE for a step, because the selector is combinational and its output must not change before `conv_valid`.
  - After DONE they hold their last values (OUT_H-1, 1) until the next `start`.
- `wr_addr` = `{row, col}` as `row*2+col`, computed in ADDR_W bits; range 0..2*OUT_H-1.
- `start` in any state other than IDLE is ignored; no queueing.
- `rf_ready` outside ISSUE is ignored.
- `conv_valid` outside WAIT is ignored; a spurious early pulse does not skip a step.
- `rf_valid` must not drop before `rf_ready` is seen. The handshake may complete in the first ISSUE cycle.
- Reset (asynchronous, any state, including mid-scan) → IDLE. Counters go to 0. All outputs go low: `busy`, `done`, `rf_valid`, `wr_en` = 0; `row_number`, `column`, `wr_addr` = 0. There is no partial-scan resume.

## Timing
- Cycle 0: `start` sampled in IDLE. Cycle 1: ISSUE, with `busy` = 1, `rf_valid` = 1, row/col = 0/0.
- Step length is 3 cycles minimum: ISSUE(1) + WAIT(≥1) + WRITE(1). This minimum holds when `rf_ready` is high on ISSUE entry and `conv_valid` arrives in the first WAIT cycle.
- Each cycle of `rf_ready` low or `conv_valid` late adds exactly one cycle.
- Minimum full scan with defaults: 56 steps × 3 = 168 cycles, plus 1 DONE cycle. `done` falls in cycle 169 after `start`. `busy` drops in the cycle after DONE.
- `wr_en` is high exactly once per step: 2*OUT_H pulses per scan, with strictly increasing `wr_addr` 0..2*OUT_H-1.
- `start` asserted in the DONE cycle is ignored. A new scan needs `start` in IDLE.

## Structure
- Shared CNN package contents:
  - State encoding (IDLE/ISSUE/WAIT/WRITE/DONE)
  - Default H/W/F constants
  - The `OUT_H`/`ADDR_W` derivation function, reused by the output-buffer block
- Sub-module `rf_scan_counter`: row/col counter with `clear`, `advance` and `last` outputs. The top holds only the FSM and the handshake decode.

## Test plan
- Full scan at defaults, `rf_ready` tied 1, `conv_valid` one cycle after ISSUE → 56 `wr_en` pulses, `wr_addr` 0..55 in order, `done` at cycle 169, 56 accepted handshakes.
- `rf_ready` held low 4 cycles on step (row 3, col 1) → `rf_valid` stays 1 and row/col stay 3/1 for 5 ISSUE cycles, then normal flow; total scan time grows by 4 cycles.
- `conv_valid` pulsed during ISSUE and during WRITE → ignored; each step still waits for `conv_valid` in WAIT; `wr_en` count stays 56.
- `start` pulsed at cycle 50 (mid-scan) and in the DONE cycle → no restart; exactly one `done` per accepted `start`.
- `rst_n` asserted asynchronously mid-WAIT at row 10 → all outputs 0 immediately; after release, a new `start` begins again at row 0, col 0, `wr_addr` 0.
- Non-default H=W=8, F=3 (OUT_H=6) → 12 writes, last `wr_addr` = 11, row_number never exceeds 5.
